// File: rtl/matmul_tile_sequencer_if.sv
// Operand-read, MAC-steering and write-back signals between the tile
// sequencer (master) and the memory / MAC / output-buffer side (slave).
interface matmul_tile_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int DEPTH  = 32
);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int KW = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;

  logic          rd_en;
  logic          rd_gnt;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic [KW-1:0] k_idx;
  logic          acc_clear;
  logic          acc_en;
  logic          wr_en;
  logic          wr_ready;

  modport master (
    output rd_en, row_idx, col_idx, k_idx, acc_clear, acc_en, wr_en,
    input  rd_gnt, wr_ready
  );

  modport slave (
    input  rd_en, row_idx, col_idx, k_idx, acc_clear, acc_en, wr_en,
    output rd_gnt, wr_ready
  );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// Control FSM for one HEIGHT x WIDTH output tile of the matmul datapath.
// Per element: DEPTH granted operand reads, PIPE_LAT drain cycles so the
// last operand reaches the MAC, then a ready-handshaked write-back.
// Optional: define MATMUL_SEQ_PERF_EN to add the o_stall_cycles counter.
module matmul_tile_sequencer #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 32,
  parameter int DEPTH    = 32,
  parameter int PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
`ifdef MATMUL_SEQ_PERF_EN
  output logic [31:0] o_stall_cycles,
`endif
  matmul_tile_sequencer_if.master bus
);
  localparam int RW = (HEIGHT   > 1) ? $clog2(HEIGHT)   : 1;
  localparam int CW = (WIDTH    > 1) ? $clog2(WIDTH)    : 1;
  localparam int KW = (DEPTH    > 1) ? $clog2(DEPTH)    : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [KW-1:0]       r_k;
  logic [DW-1:0]       r_drain;
  logic [PIPE_LAT-1:0] r_en_pipe, r_clr_pipe;

  logic w_grant, w_k_last, w_drain_last, w_col_last, w_row_last, w_wr_acc;

  assign w_grant      = (r_state == S_ISSUE) & bus.rd_gnt;
  assign w_k_last     = (r_k == KW'(DEPTH - 1));
  assign w_drain_last = (r_drain == DW'(PIPE_LAT - 1));
  assign w_col_last   = (r_col == CW'(WIDTH - 1));
  assign w_row_last   = (r_row == RW'(HEIGHT - 1));
  // An abort in WRITE kills wr_en in the same cycle, so no write is accepted.
  assign w_wr_acc     = (r_state == S_WRITE) & bus.wr_ready & ~i_abort;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; abort from any state forces IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_ISSUE;
      S_ISSUE: if (w_grant && w_k_last) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_last) w_next = S_WRITE;
      S_WRITE: if (bus.wr_ready) w_next = (w_col_last && w_row_last) ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  // Element / inner-product indices and drain counter
  always_ff @(posedge clk) begin
    if (!rst || i_abort) begin
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_row <= '0;
          r_col <= '0;
          r_k   <= '0;
        end
        S_ISSUE: if (w_grant) r_k <= w_k_last ? '0 : r_k + KW'(1);
        S_DRAIN: r_drain <= w_drain_last ? '0 : r_drain + DW'(1);
        S_WRITE: if (w_wr_acc) begin
          if (!w_col_last) begin
            r_col <= r_col + CW'(1);
          end else if (!w_row_last) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end
        end
        S_DONE: begin
          r_row <= '0;
          r_col <= '0;
          r_k   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Grant pipeline: delays each granted read (and its k==0 flag) to the MAC
  always_ff @(posedge clk) begin
    if (!rst || i_abort) begin
      r_en_pipe  <= '0;
      r_clr_pipe <= '0;
    end else begin
      r_en_pipe[0]  <= w_grant;
      r_clr_pipe[0] <= w_grant & (r_k == '0);
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_en_pipe[i]  <= r_en_pipe[i-1];
        r_clr_pipe[i] <= r_clr_pipe[i-1];
      end
    end
  end

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] r_stall;
  // Stall counter: starved reads plus back-pressured writes, saturating
  always_ff @(posedge clk) begin
    if (!rst)
      r_stall <= '0;
    else if (r_state == S_IDLE && i_start && !i_abort)
      r_stall <= '0;
    else if (((r_state == S_ISSUE && !bus.rd_gnt) ||
              (r_state == S_WRITE && !bus.wr_ready)) && r_stall != '1)
      r_stall <= r_stall + 32'd1;
  end
  assign o_stall_cycles = r_stall;
`endif

  assign bus.rd_en     = (r_state == S_ISSUE);
  assign bus.row_idx   = r_row;
  assign bus.col_idx   = r_col;
  assign bus.k_idx     = r_k;
  assign bus.acc_en    = r_en_pipe[PIPE_LAT-1];
  assign bus.acc_clear = r_clr_pipe[PIPE_LAT-1];
  assign bus.wr_en     = (r_state == S_WRITE) & ~i_abort;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE) & ~i_abort;
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Scoreboard bench for matmul_tile_sequencer (2x2 tile, DEPTH 3, PIPE_LAT 2).
// Stimulus pushes the expected element order on start acceptance; a negedge
// monitor checks reads, MAC steering, write-back order and done timing.
module tb_matmul_tile_sequencer;
  localparam int W = 2, H = 2, D = 3, PL = 2;
  localparam int ELEM = D + PL + 1;

  logic clk = 0, rst = 0, start = 0, abort = 0;
  logic busy, done;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] stall;
`endif

  matmul_tile_sequencer_if #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) bus ();

  matmul_tile_sequencer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .o_busy(busy), .o_done(done),
`ifdef MATMUL_SEQ_PERF_EN
    .o_stall_cycles(stall),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct { int t; int clr; } acc_t;
  typedef struct { int r; int c; } el_t;
  acc_t aq[$];
  el_t  wq[$];
  bit   m_busy = 0;
  int   exp_k = 0, acc_cnt = 0, last_grant = 0, exp_done = -1;
  int   done_cnt = 0, last_done = -1, m_stall = 0;
  bit   prev_wr = 0;

  always @(negedge clk) begin
    bit   acc_start;
    acc_t a;
    el_t  e;
    acc_start = rst && start && !abort && !m_busy;
    if (rst) check("busy", busy, m_busy);
    if (rst && m_busy) begin
      if (bus.rd_en && !bus.rd_gnt)   m_stall++;
      if (bus.wr_en && !bus.wr_ready) m_stall++;
    end
    if (bus.rd_en && bus.rd_gnt) begin
      check("k_idx", bus.k_idx, exp_k);
      if (wq.size() > 0) begin
        check("rd_row", bus.row_idx, wq[0].r);
        check("rd_col", bus.col_idx, wq[0].c);
      end
      aq.push_back('{cyc + PL, (exp_k == 0)});
      last_grant = cyc;
      exp_k = (exp_k + 1) % D;
    end
    if (aq.size() > 0 && aq[0].t < cyc) begin
      check("acc_missing", 0, 1);
      void'(aq.pop_front());
    end
    if (bus.acc_en) begin
      if (aq.size() == 0) check("acc_unexpected", 1, 0);
      else begin
        a = aq.pop_front();
        check("acc_time", cyc, a.t);
        check("acc_clear", bus.acc_clear, a.clr);
        acc_cnt++;
      end
    end else if (bus.acc_clear) check("clear_without_en", 1, 0);
    if (bus.wr_en && !prev_wr) check("wr_latency", cyc, last_grant + PL + 1);
    if (bus.wr_en && bus.wr_ready) begin
      if (wq.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = wq.pop_front();
        check("wr_row", bus.row_idx, e.r);
        check("wr_col", bus.col_idx, e.c);
        check("acc_per_elem", acc_cnt, D);
        acc_cnt = 0;
        if (wq.size() == 0) exp_done = cyc + 1;
      end
    end
    if (done) begin
      check("done_time", cyc, exp_done);
`ifdef MATMUL_SEQ_PERF_EN
      check("stall_cycles", stall, m_stall);
`endif
      done_cnt++;
      last_done = cyc;
      exp_done = -1;
      m_busy = 0;
    end else if (rst && !abort && cyc == exp_done) check("done_missing", 0, 1);
    prev_wr = bus.wr_en;
    if (!rst || (abort && m_busy)) begin
      wq.delete(); aq.delete();
      exp_k = 0; acc_cnt = 0; exp_done = -1; m_busy = 0; prev_wr = 0;
    end else if (acc_start) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) wq.push_back('{r, c});
      m_busy = 1; exp_k = 0; acc_cnt = 0; m_stall = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic go_to(int t);
    while (cyc < t) step();
  endtask
  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask
  task automatic wait_done(int budget);
    int d0 = done_cnt, n = 0;
    while (done_cnt == d0 && n < budget) begin step(); n++; end
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask
  task automatic idle_outputs(string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_rd_en"}, bus.rd_en, 0);
    check({name, "_wr_en"}, bus.wr_en, 0);
    check({name, "_acc_en"}, bus.acc_en, 0);
    check({name, "_done"}, done, 0);
    check({name, "_idx"}, {bus.row_idx, bus.col_idx, bus.k_idx}, 0);
  endtask

  initial begin
    int st, d0;
    bus.rd_gnt = 1; bus.wr_ready = 1;
    step(); step(); step();
    idle_outputs("reset");
    rst = 1; step(); step();

    // uncontended tile
    st = cyc; pulse_start();
    check("busy_rise", busy, 1);
    go_to(st + 3);
    check("first_acc_en", bus.acc_en, 1);
    check("first_acc_clr", bus.acc_clear, 1);
    go_to(st + 6);
    check("first_wr_en", bus.wr_en, 1);
    wait_done(200);
    check("done_uncontended", last_done - st, H*W*ELEM + 1);
    step();

    // grant stall at k=1
    st = cyc; pulse_start();
    go_to(st + 2);
    check("stall_k_entry", bus.k_idx, 1);
    bus.rd_gnt = 0;
    repeat (4) begin
      check("stall_k_hold", bus.k_idx, 1);
      check("stall_rd_en", bus.rd_en, 1);
      step();
    end
    bus.rd_gnt = 1;
    wait_done(200);
    check("done_gnt_stall", last_done - st, H*W*ELEM + 1 + 4);
    step();

    // write backpressure at element (0,1)
    st = cyc; pulse_start();
    go_to(st + 12);
    bus.wr_ready = 0;
    repeat (5) begin
      check("bp_wr_en", bus.wr_en, 1);
      check("bp_col", bus.col_idx, 1);
      check("bp_row", bus.row_idx, 0);
      step();
    end
    bus.wr_ready = 1;
    wait_done(200);
    check("done_backpressure", last_done - st, H*W*ELEM + 1 + 5);
`ifdef MATMUL_SEQ_PERF_EN
    step();
    check("stall_hold_idle", stall, 5);
`endif
    step();

    // abort in DRAIN of element (1,0)
    st = cyc; pulse_start();
    go_to(st + 16);
    d0 = done_cnt;
    abort = 1; step(); abort = 0;
    idle_outputs("abort");
    repeat (30) step();
    check("abort_no_done", done_cnt, d0);
    st = cyc; pulse_start();
    wait_done(200);
    check("done_after_abort", last_done - st, H*W*ELEM + 1);
    step();

    // start and abort together in IDLE
    start = 1; abort = 1; step(); start = 0; abort = 0;
    check("abort_beats_start", busy, 0);

    // reset mid-WRITE
    st = cyc; pulse_start();
    go_to(st + 6);
    check("rst_pre_wr_en", bus.wr_en, 1);
    rst = 0; step(); rst = 1;
    idle_outputs("midrst");
    step();

    // start pulses while busy are ignored
    st = cyc; d0 = done_cnt; pulse_start();
    go_to(st + 5);  pulse_start();
    go_to(st + 10); pulse_start();
    wait_done(200);
    check("done_ignore_start", last_done - st, H*W*ELEM + 1);
    repeat (40) step();
    check("single_done", done_cnt - d0, 1);

    // randomized grant / ready pressure
    for (int run = 0; run < 8; run++) begin
      int n = 0;
      d0 = done_cnt;
      pulse_start();
      while (done_cnt == d0 && n < 2000) begin
        bus.rd_gnt   = ($urandom_range(0, 3) != 0);
        bus.wr_ready = ($urandom_range(0, 2) != 0);
        step(); n++;
      end
      if (done_cnt == d0) check("rand_done_timeout", 0, 1);
      bus.rd_gnt = 1; bus.wr_ready = 1;
      step();
    end
    check("total_done", done_cnt, 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
